// File: rtl/execute_muldiv_unit_pkg.sv
// rtl/execute_muldiv_unit_pkg.sv - shared types and constants for the multiply/divide unit
//
// Purpose: operation and FSM state encodings used by execute_muldiv_unit and
//          the execute stage that drives it.
// Ports:   none (package).

package execute_muldiv_unit_pkg;

  // Largest number of radix-2 steps chained into one cycle.
  localparam int MDU_MAX_UNROLL = 4;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_type;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    SPECIAL = 2'd2,
    DONE    = 2'd3
  } mdu_state_type;

endpackage

// File: rtl/mdu_radix2_step.sv
// rtl/mdu_radix2_step.sv - one combinational shift-add / restoring-subtract step
//
// Purpose: advances the {high, low} accumulator by one multiplier or quotient bit.
// Ports:
//   i_is_div   1       1 = restoring divide step, 0 = shift-add multiply step
//   i_operand  XLEN    multiplicand magnitude (multiply) or divisor magnitude (divide)
//   i_acc      2*XLEN  accumulator in: multiply {partial, multiplier}, divide {remainder, dividend/quotient}
//   o_acc      2*XLEN  accumulator out

module mdu_radix2_step #(
  parameter int XLEN = 32
) (
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_operand,
  input  logic [2*XLEN-1:0] i_acc,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0] w_add_sum;
  logic [XLEN:0] w_trial;
  logic [XLEN:0] w_diff;

  // Multiply: add the multiplicand when the current multiplier bit is set; the
  // carry out lands in the top bit after the right shift.
  assign w_add_sum = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_operand} : '0);

  // Divide: bring the next dividend bit into the remainder. The remainder is
  // always below the divisor, so one extra bit is enough to detect the borrow.
  assign w_trial = i_acc[2*XLEN-1:XLEN-1];
  assign w_diff  = w_trial - {1'b0, i_operand};

  always_comb begin
    o_acc = '0;
    if (i_is_div) begin
      if (w_diff[XLEN]) begin
        o_acc = {w_trial[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
      end else begin
        o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
      end
    end else begin
      o_acc = {w_add_sum, i_acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/execute_muldiv_unit.sv
// rtl/execute_muldiv_unit.sv - iterative RV32M/RV64M multiply/divide unit for the execute stage
//
// Purpose: computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over XLEN/UNROLL
//          cycles and holds the pipeline through stall until the result is ready.
// Ports:
//   clk        in   1     rising-edge clock
//   reset_n    in   1     asynchronous active-low reset
//   start      in   1     request, sampled only in IDLE
//   op         in   3     muldiv_op_type, sampled with start
//   operand_a  in   XLEN  rs1 after forwarding, sampled with start
//   operand_b  in   XLEN  rs2 after forwarding, sampled with start
//   flush      in   1     abort the current operation
//   busy       out  1     operation in progress
//   done       out  1     one-cycle pulse, result valid
//   result     out  XLEN  last completed result, held until the next done
//   stall      out  1     freeze request to the hazard unit

module execute_muldiv_unit
  import execute_muldiv_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  // Out-of-range unroll factors are clamped so the step chain stays bounded.
  localparam int STEPS_PER_CYCLE = (UNROLL > MDU_MAX_UNROLL) ? MDU_MAX_UNROLL : UNROLL;
  localparam int STEPS           = XLEN / STEPS_PER_CYCLE;
  localparam int CW              = (STEPS > 1) ? $clog2(STEPS) : 1;

  mdu_state_type   r_state;
  mdu_state_type   w_state_next;
  muldiv_op_type   r_op;
  muldiv_op_type   w_op;
  logic            r_sign_a;
  logic            r_sign_b;
  logic [XLEN-1:0] r_mag_b;
  logic [2*XLEN-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_special;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_is_div;
  logic            w_is_rem;
  logic            w_div_zero;
  logic            w_overflow;
  logic [XLEN-1:0] w_special_val;
  logic            w_r_is_div;
  logic [2*XLEN-1:0] w_final;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_quot;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_result_calc;

  // ---------------------------------------------------------------- capture
  assign w_op     = muldiv_op_type'(op);
  assign w_accept = (r_state == IDLE) & start & ~flush;

  assign w_neg_a = (w_op inside {MULH, MULHSU, DIV, REM}) & operand_a[XLEN-1];
  assign w_neg_b = (w_op inside {MULH, DIV, REM}) & operand_b[XLEN-1];
  assign w_mag_a = w_neg_a ? -operand_a : operand_a;
  assign w_mag_b = w_neg_b ? -operand_b : operand_b;

  assign w_is_div   = w_op inside {DIV, DIVU, REM, REMU};
  assign w_is_rem   = w_op inside {REM, REMU};
  assign w_div_zero = w_is_div & (operand_b == '0);
  assign w_overflow = (w_op inside {DIV, REM}) &
                      (operand_a == {1'b1, {(XLEN-1){1'b0}}}) & (operand_b == '1);

  always_comb begin
    w_special_val = '0;
    if (w_div_zero) begin
      w_special_val = w_is_rem ? operand_a : '1;
    end else if (w_overflow) begin
      w_special_val = w_is_rem ? '0 : operand_a;
    end
  end

  // ---------------------------------------------------------- step chain
  assign w_r_is_div = r_op inside {DIV, DIVU, REM, REMU};

  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
    logic [2*XLEN-1:0] w_in;
    logic [2*XLEN-1:0] w_out;
    if (g == 0) begin : g_first
      assign w_in = r_acc;
    end else begin : g_next
      assign w_in = g_step[g-1].w_out;
    end
    mdu_radix2_step #(.XLEN(XLEN)) u_step (
      .i_is_div  (w_r_is_div),
      .i_operand (r_mag_b),
      .i_acc     (w_in),
      .o_acc     (w_out)
    );
  end

  assign w_final = g_step[STEPS_PER_CYCLE-1].w_out;

  // Sign correction on the final accumulator, used only on COMPUTE -> DONE.
  assign w_prod = (r_sign_a ^ r_sign_b) ? -w_final : w_final;
  assign w_quot = (r_sign_a ^ r_sign_b) ? -w_final[XLEN-1:0] : w_final[XLEN-1:0];
  assign w_rem  = r_sign_a ? -w_final[2*XLEN-1:XLEN] : w_final[2*XLEN-1:XLEN];

  always_comb begin
    w_result_calc = '0;
    case (r_op)
      MUL:                 w_result_calc = w_prod[XLEN-1:0];
      MULH, MULHSU, MULHU: w_result_calc = w_prod[2*XLEN-1:XLEN];
      DIV, DIVU:           w_result_calc = w_quot;
      default:             w_result_calc = w_rem;
    endcase
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = (w_div_zero | w_overflow) ? SPECIAL : COMPUTE;
        end
      end
      COMPUTE: begin
        busy = 1'b1;
        if (flush) begin
          w_state_next = IDLE;
        end else if (r_cnt == CW'(STEPS - 1)) begin
          w_state_next = DONE;
        end
      end
      SPECIAL: begin
        busy         = 1'b1;
        w_state_next = flush ? IDLE : DONE;
      end
      default: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op      <= MUL;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_mag_b   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_special <= '0;
      r_result  <= '0;
    end else begin
      if (w_accept) begin
        r_op      <= w_op;
        r_sign_a  <= w_neg_a;
        r_sign_b  <= w_neg_b;
        r_mag_b   <= w_mag_b;
        r_acc     <= {{XLEN{1'b0}}, w_mag_a};
        r_cnt     <= '0;
        r_special <= w_special_val;
      end else if (r_state == COMPUTE) begin
        r_acc <= w_final;
        r_cnt <= r_cnt + CW'(1);
      end
      // A flush leaves the next state at IDLE, so the held result survives it.
      if (w_state_next == DONE) begin
        r_result <= (r_state == SPECIAL) ? r_special : w_result_calc;
      end
    end
  end

  assign result = r_result;
  assign stall  = w_accept | busy;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// tb/tb_execute_muldiv_unit.sv - self-checking bench for execute_muldiv_unit
//
// Purpose: drives directed operations into a UNROLL=1 and a UNROLL=4 instance and
//          checks them against an arithmetic reference and hand-computed values.
// Ports:   none (top-level bench).

module tb_execute_muldiv_unit;
  import execute_muldiv_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1_n, start1, flush1, busy1, done1, stall1;
  logic [2:0]  op1;
  logic [31:0] a1, b1, result1;
  logic        rst4_n, start4, flush4, busy4, done4, stall4;
  logic [2:0]  op4;
  logic [31:0] a4, b4, result4;

  int n_checks = 0;
  int n_pass   = 0;

  execute_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut1 (
    .clk(clk), .reset_n(rst1_n), .start(start1), .op(op1), .operand_a(a1), .operand_b(b1),
    .flush(flush1), .busy(busy1), .done(done1), .result(result1), .stall(stall1)
  );

  execute_muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (
    .clk(clk), .reset_n(rst4_n), .start(start4), .op(op4), .operand_a(a4), .operand_b(b4),
    .flush(flush4), .busy(busy4), .done(done4), .result(result4), .stall(stall4)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // ------------------------------------------------ arithmetic reference
  function automatic bit ref_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit is_div = (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
    bit ovf    = ((op == DIV) || (op == REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    return (is_div && (b == 0)) || ovf;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return ref_special(op, a, b) ? 2 : 33;
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint          za = longint'({32'b0, a});
    longint          zb = longint'({32'b0, b});
    longint unsigned pu = 64'(a) * 64'(b);
    longint          p;
    bit              ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MUL:    begin p = sa * sb; return p[31:0];  end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * zb; return p[63:32]; end
      MULHU:  return pu[63:32];
      DIV:    begin if (b == 0) return 32'hFFFF_FFFF; if (ovf) return a; p = sa / sb; return p[31:0]; end
      DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; p = za / zb; return p[31:0]; end
      REM:    begin if (b == 0) return a; if (ovf) return 32'h0; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = za % zb; return p[31:0]; end
    endcase
  endfunction

  // Transaction-level model of dut1: which cycle of an operation we are in,
  // when done is due, and what result is held.
  bit          m_active;
  int          m_cyc, m_lat;
  logic [31:0] m_exp, m_result;

  always @(posedge clk or negedge rst1_n) begin
    if (!rst1_n) begin
      m_active = 0; m_cyc = 0; m_lat = 0; m_exp = 0; m_result = 0;
    end else if (m_active) begin
      if (m_cyc == m_lat) m_active = 0;
      else if (flush1) m_active = 0;
      else begin
        m_cyc++;
        if (m_cyc == m_lat) m_result = m_exp;
      end
    end else if (start1 && !flush1) begin
      m_active = 1;
      m_cyc    = 1;
      m_lat    = ref_latency(op1, a1, b1);
      m_exp    = ref_result(op1, a1, b1);
    end
  end

  always @(negedge clk) begin
    if (rst1_n) begin
      chk("cyc_busy",   busy1,   m_active && (m_cyc < m_lat));
      chk("cyc_done",   done1,   m_active && (m_cyc == m_lat));
      chk("cyc_result", result1, m_result);
      chk("cyc_stall",  stall1,  (start1 && !m_active && !flush1) || (m_active && (m_cyc < m_lat)));
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic issue(input logic [2:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i);
    start1 = 1'b1; flush1 = 1'b0; op1 = op_i; a1 = a_i; b1 = b_i;
  endtask

  // Operands are scrambled every cycle after capture; optional flush and
  // a stray start are injected at the given cycles (0 = none).
  task automatic wait_done(input string name, input logic [31:0] exp, input int lat,
                           input int flush_cyc, input int poke_cyc);
    int cyc = 0;
    bit got = 0;
    while (!got && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      start1 = (cyc == poke_cyc);
      flush1 = (cyc == flush_cyc);
      op1 = 3'($urandom); a1 = $urandom; b1 = $urandom;
      @(negedge clk);
      got = done1;
    end
    chk({name, "_latency"}, 64'(cyc), 64'(lat));
    chk({name, "_result"}, result1, exp);
  endtask

  task automatic run_op(input string name, input logic [2:0] op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input logic [31:0] exp, input int lat,
                        input int flush_cyc, input int poke_cyc);
    @(posedge clk); #1;
    issue(op_i, a_i, b_i);
    wait_done(name, exp, lat, flush_cyc, poke_cyc);
  endtask

  task automatic run4(input string name, input logic [2:0] op_i, input logic [31:0] a_i,
                      input logic [31:0] b_i, input logic [31:0] exp, input int lat);
    int cyc = 0;
    bit got = 0;
    @(posedge clk); #1;
    start4 = 1'b1; op4 = op_i; a4 = a_i; b4 = b_i;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      start4 = 1'b0; a4 = $urandom; b4 = $urandom;
      @(negedge clk);
      got = done4;
    end
    chk({name, "_latency"}, 64'(cyc), 64'(lat));
    chk({name, "_result"}, result4, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst1_n = 0; start1 = 0; flush1 = 0; op1 = 0; a1 = 0; b1 = 0;
    rst4_n = 0; start4 = 0; flush4 = 0; op4 = 0; a4 = 0; b4 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",    busy1,   0);
    chk("reset_done",    done1,   0);
    chk("reset_result",  result1, 0);
    chk("reset_stall",   stall1,  0);
    chk("reset4_result", result4, 0);
    @(posedge clk); #1;
    rst1_n = 1; rst4_n = 1;

    // Pin the reference against hand-computed values.
    chk("ref_mul",    ref_result(MUL,    32'd7,          32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("ref_mulhsu", ref_result(MULHSU, 32'hFFFF_FFFF,  32'd2),         32'hFFFF_FFFF);
    chk("ref_div",    ref_result(DIV,    32'hFFFF_FFF9,  32'd2),         32'hFFFF_FFFD);
    chk("ref_rem",    ref_result(REM,    32'hFFFF_FFF9,  32'd2),         32'hFFFF_FFFF);
    chk("ref_lat",    64'(ref_latency(REM, 32'd5, 32'd0)),               64'd2);

    run_op("mul_neg",  MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0, 5);
    run_op("mulhu",    MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0, 0);
    run_op("mulh",     MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 0, 0);
    run_op("mulhsu",   MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 0, 0);
    run_op("mulh_min", MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0, 0);
    run_op("div_neg",  DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 0, 0);
    run_op("rem_neg",  REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 0, 0);
    run_op("rem_nn",   REM,    32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, 0, 0);
    run_op("divu",     DIVU,   32'd100,       32'd7,         32'd14,        33, 0, 0);
    run_op("remu_fdn", REMU,   32'd100,       32'd7,         32'd2,         33, 33, 0);

    // Flush in cycle 10 of a multiply; restart in cycle 11.
    @(posedge clk); #1;
    issue(MUL, 32'd11, 32'd13);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      flush1 = (c == 10);
    end
    @(posedge clk); #1;
    issue(DIVU, 32'd100, 32'd7);
    @(negedge clk);
    chk("flush_busy_c11",   busy1,   0);
    chk("flush_done_c11",   done1,   0);
    chk("flush_result_kept", result1, 32'd2);
    wait_done("after_flush", 32'd14, 33, 0, 0);

    // start together with flush while idle: nothing starts.
    @(posedge clk); #1;
    start1 = 1'b1; flush1 = 1'b1; op1 = MUL; a1 = 32'd3; b1 = 32'd4;
    @(negedge clk);
    chk("start_flush_stall", stall1, 0);
    @(posedge clk); #1;
    start1 = 1'b0; flush1 = 1'b0;
    @(negedge clk);
    chk("start_flush_busy", busy1, 0);

    run_op("divu_zero", DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 2, 0, 0);
    run_op("rem_zero",  REM,  32'd5,         32'd0,         32'd5,         2, 0, 0);
    run_op("div_ovf",   DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0, 0);
    run_op("rem_ovf",   REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         2, 0, 0);

    // UNROLL = 4 instance.
    run4("u4_div", DIV, 32'd1000, 32'd3,         32'd333,       9);
    run4("u4_mul", MUL, 32'd7,    32'hFFFF_FFFD, 32'hFFFF_FFEB, 9);
    @(posedge clk); #1;
    start4 = 1'b1; op4 = MULHU; a4 = 32'hFFFF_FFFF; b4 = 32'hFFFF_FFFF;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start4 = 1'b0;
    end
    chk("u4_busy_c5", busy4, 1);
    #2;
    rst4_n = 1'b0;
    #1;
    chk("u4_reset_busy",   busy4,   0);
    chk("u4_reset_done",   done4,   0);
    chk("u4_reset_result", result4, 0);
    @(posedge clk); #1;
    rst4_n = 1'b1;

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/execute_muldiv_unit.md
# execute_muldiv_unit

Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the ALU in the execute stage. It takes already-forwarded operands, computes over several cycles, and holds the EX stage through `stall` until the result is ready. Width and bits-per-cycle are generic, so the same block serves RV32 and RV64 and different area/latency points.

## Interface
Parameters:
- `XLEN`, default 32: operand/result width.
- `UNROLL`, default 1: radix-2 steps per cycle. Legal values are 1, 2, 4, and the value must divide `XLEN`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request. Sampled only in IDLE.
- `op`  in  3  `muldiv_op_type`. Sampled with `start`.
- `operand_a`  in  XLEN  rs1 value after forwarding. Sampled with `start`.
- `operand_b`  in  XLEN  rs2 value after forwarding. Sampled with `start`.
- `flush`  in  1  abort the current operation (branch mispredict or pipeline kill).
- `busy`  out  1  an operation is in progress (registered).
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  XLEN  last completed result. Held until the next `done`.
- `stall`  out  1  combinational: `(start & state==IDLE & ~flush) | busy`. Hazard unit freezes PC, IF/ID and ID/EX while it is 1.

## Operation
- FSM states:
  - IDLE: `start & ~flush` goes to SPECIAL if the operation is a divide by zero or signed overflow, otherwise to COMPUTE.
  - COMPUTE: runs `XLEN/UNROLL` cycles, then goes to DONE.
  - SPECIAL: goes to DONE next cycle.
  - DONE: goes to IDLE.
  - `flush` in any non-IDLE state goes to IDLE next cycle. No `done` is produced and `result` is unchanged.
- Capture at start:
  - Store operand magnitudes and sign flags.
  - sign_a is used for MULH, MULHSU, DIV, REM.
  - sign_b is used for MULH, DIV, REM.
- Multiply:
  - Shift-add on magnitudes into a 2·XLEN accumulator, `UNROLL` multiplier bits per cycle.
  - Negate the product if sign_a ^ sign_b.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes, `UNROLL` quotient bits per cycle.
  - Quotient sign is sign_a ^ sign_b; remainder sign is sign_a.
- Special cases (RISC-V spec):
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return `operand_a`.
  - Signed overflow (`operand_a` = 1<<(XLEN-1), `operand_b` = −1): DIV returns `operand_a`; REM returns 0.
- Sign correction is applied when `result` is registered on the COMPUTE→DONE transition.
- `start` while busy is ignored. `op`/operand changes after capture have no effect.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, all internal accumulators 0.

## Timing
- `start` is accepted at edge 0.
- Normal path:
  - `busy`=1 from cycle 1 through cycle `XLEN/UNROLL`.
  - `done`=1 in cycle `XLEN/UNROLL`+1 (33 for the defaults).
  - `busy`=0 in the `done` cycle, so `stall` drops and EX advances with `result` in that same cycle.
- Special path: `busy` in cycle 1, `done` in cycle 2.
- Back-to-back: the next `start` is accepted in the cycle after `done` at the earliest.
- Simultaneous `start` and `flush` in IDLE: flush wins, nothing starts.
- `flush` in the DONE cycle: `done` still pulses; the pipeline discards it.
- Asynchronous reset mid-operation: all outputs go to reset values immediately.

## Structure
- Add to `common`:
  - `muldiv_op_type` enum: MUL=0, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - `mdu_state_type` enum: IDLE, COMPUTE, SPECIAL, DONE.
  - a `MDU_MAX_UNROLL` constant.
- One sub-module, `mdu_radix2_step`: one combinational shift-add / restore-subtract step, instantiated `UNROLL` times via generate.
- The execute stage muxes `result` onto `alu_data` when the control word marks an M-extension operation.

## Test plan
- MUL, a=7, b=0xFFFFFFFD (−3) → `result`=0xFFFFFFEB; `done` in cycle 33; `stall` high cycles 0–32.
- MULHU, a=b=0xFFFFFFFF → 0xFFFFFFFE; MULH with the same operands → 0x00000000; MULHSU, a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with `done` in cycle 2; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM of the same → 0.
- Start MUL, `flush` in cycle 10 → no `done`, `busy`=0 in cycle 11, `result` keeps its prior value; a new `start` in cycle 11 completes normally.
- `UNROLL`=4, DIV 1000/3 → 333 with `done` in cycle 9; assert `reset_n` low in cycle 5 of a second operation → `busy`, `done`, `result` all 0 at once.
